// File: rtl/simon_rng_sched.sv
// Round-robin sequencer that shares one RNG+SIMON engine between two requesters,
// loading the two key words before use. Define SIMON_SCHED_STATS_EN for enc/rekey counters.
module simon_rng_sched #(
    parameter logic [8:0] KEY_BASE       = 9'h10,
    parameter int         REKEY_INTERVAL = 16,
    parameter int         TIMEOUT        = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_pt,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_pt,
    output logic        req1_ready,
    input  logic        force_rekey,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_ct,
    output logic        rsp_err,
    output logic        key_we,
    output logic [8:0]  key_addr,
    input  logic        key_ack,
    output logic        cipher_en,
    output logic [31:0] plaintext,
    input  logic [31:0] cipher_out,
    input  logic        done,
    output logic        busy,
`ifdef SIMON_SCHED_STATS_EN
    output logic [15:0] enc_count,
    output logic [7:0]  rekey_count,
`endif
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        IDLE, KEY0, KEY0_CLR, KEY1, KEY1_CLR, START, WAIT_DONE, RESP
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 2);

    state_t        state, state_nxt;
    logic          key_valid;
    logic [15:0]   enc_cnt;
    logic          last_gnt;
    logic          rekey_pend;
    logic [TW-1:0] tmo_cnt;

    logic rekey_due, tmo_hit, gnt_sel;
    logic do_grant, do_done, do_tmo;

    assign rekey_due = !key_valid || rekey_pend || force_rekey ||
                       ((REKEY_INTERVAL != 0) && (enc_cnt >= 16'(REKEY_INTERVAL)));
    assign tmo_hit   = (tmo_cnt >= TW'(TIMEOUT - 1));
    // With both requesting, the one not served last wins; otherwise whoever asks.
    assign gnt_sel   = (req0_valid && req1_valid) ? !last_gnt : req1_valid;

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_done   = 1'b0;
        do_tmo    = 1'b0;
        case (state)
            IDLE: begin
                if (rekey_due) begin
                    state_nxt = KEY0;
                end else if (req0_valid || req1_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = START;
                end
            end
            KEY0: begin
                if (key_ack) begin
                    state_nxt = KEY0_CLR;
                end else if (tmo_hit) begin
                    do_tmo    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            KEY0_CLR: state_nxt = KEY1;
            KEY1: begin
                if (key_ack) begin
                    state_nxt = KEY1_CLR;
                end else if (tmo_hit) begin
                    do_tmo    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            KEY1_CLR: state_nxt = IDLE;
            START:    state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (done) begin
                    do_done   = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    do_tmo    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= KEY0;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with the state
    // they describe and are all low in the cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_valid   <= 1'b0;
            enc_cnt     <= '0;
            last_gnt    <= 1'b1;
            rekey_pend  <= 1'b0;
            tmo_cnt     <= '0;
            key_we      <= 1'b0;
            key_addr    <= KEY_BASE;
            cipher_en   <= 1'b0;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            plaintext   <= '0;
            rsp_id      <= 1'b0;
            rsp_ct      <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt    <= (state_nxt == state) ? tmo_cnt + 1'b1 : '0;
            key_we     <= (state_nxt == KEY0) || (state_nxt == KEY1);
            key_addr   <= (state_nxt == KEY1) ? KEY_BASE + 9'd1 : KEY_BASE;
            cipher_en  <= (state_nxt == START);
            rsp_valid  <= (state_nxt == RESP);
            busy       <= (state_nxt != IDLE);
            req0_ready <= do_grant && !gnt_sel;
            req1_ready <= do_grant && gnt_sel;

            // A force_rekey arriving as KEY0 is entered is covered by that load.
            if (state_nxt == KEY0 && state != KEY0) begin
                rekey_pend <= 1'b0;
            end else if (force_rekey) begin
                rekey_pend <= 1'b1;
            end

            if (do_grant) begin
                plaintext <= gnt_sel ? req1_pt : req0_pt;
                rsp_id    <= gnt_sel;
                last_gnt  <= gnt_sel;
            end

            if (do_done) begin
                rsp_ct  <= cipher_out;
                rsp_err <= 1'b0;
                if (enc_cnt != 16'hFFFF) enc_cnt <= enc_cnt + 16'd1;
            end

            if (do_tmo) begin
                err_timeout <= 1'b1;
                key_valid   <= 1'b0;
                if (state == WAIT_DONE) begin
                    rsp_ct  <= '0;
                    rsp_err <= 1'b1;
                end
            end

            if (state == KEY1_CLR) begin
                key_valid <= 1'b1;
                enc_cnt   <= '0;
            end
        end
    end

`ifdef SIMON_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            enc_count   <= '0;
            rekey_count <= '0;
        end else begin
            if (do_done && enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
            if (state == KEY1_CLR && rekey_count != 8'hFF) rekey_count <= rekey_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/simon_rng_sched.md
Name: simon_rng_sched

Overview:
- Sequencer/arbiter in front of the RNG + SIMON top (simonrngtop).
- Shares the single cipher engine between two plaintext requesters using round-robin grant.
- Drives the RNG key-word write handshake (two words) before first use and periodically thereafter.
- Pulses cipher start, captures ciphertext on done, returns a tagged response; guards every engine wait with a timeout.

Parameters:
- KEY_BASE, 9'h10, RAM address of key word 0; key word 1 at KEY_BASE+1 (9-bit wrap: 9'h1FF -> 9'h000).
- REKEY_INTERVAL, 16, completed encryptions between automatic key refreshes; 0 = never auto-rekey.
- TIMEOUT, 1023, max cycles spent waiting for key_ack or done before error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has plaintext
- req0_pt / req1_pt  in  32  plaintext, stable while valid && !ready
- req0_ready / req1_ready  out  1  one-cycle accept pulse
- force_rekey  in  1  pulse: rekey before next grant
- rsp_valid  out  1  response available, held until rsp_ready
- rsp_ready  in  1  response consumer accept
- rsp_id  out  1  requester index of response
- rsp_ct  out  32  ciphertext
- rsp_err  out  1  response aborted by timeout
- key_we  out  1  RNG key write request to engine
- key_addr  out  9  RNG key write address
- key_ack  in  1  engine key write acknowledge
- cipher_en  out  1  one-cycle cipher start
- plaintext  out  32  engine plaintext
- cipher_out  in  32  engine ciphertext
- done  in  1  engine completion (level)
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset (rst==0 at posedge): state=KEY0, key_valid=0, enc_cnt=0, rr pointer -> req0 has priority. All outputs 0; key_addr=KEY_BASE.
- States: IDLE, KEY0, KEY0_CLR, KEY1, KEY1_CLR, START, WAIT_DONE, RESP.
- KEY0/KEY1: key_we=1, key_addr=KEY_BASE (+1 for KEY1). Advance to *_CLR on the first cycle key_ack is sampled 1. *_CLR: key_we=0 for exactly one cycle. KEY1_CLR -> set key_valid, clear enc_cnt -> IDLE.
- IDLE: if !key_valid, pending force_rekey, or (REKEY_INTERVAL!=0 && enc_cnt==REKEY_INTERVAL) -> KEY0. Otherwise grant:
  - If one request is valid, grant it.
  - If both are valid, grant the one not granted last.
  - Grant: reqN_ready=1 for one cycle, latch pt into plaintext, rsp_id=N, update pointer -> START. Rekey takes precedence over grant in the same cycle.
- force_rekey is latched when seen in any state; it is consumed on entry to KEY0.
- START: cipher_en=1 for exactly one cycle -> WAIT_DONE. plaintext held from grant until RESP exit.
- WAIT_DONE: on first cycle done==1, capture cipher_out into rsp_ct, rsp_err=0, enc_cnt+1 (saturating) -> RESP.
- RESP: rsp_valid=1 until rsp_ready sampled 1, then IDLE. No grant while a response is pending.
- Timeout: counter reset on entry to KEY0, KEY1, WAIT_DONE. When it reaches TIMEOUT without ack/done:
  - err_timeout=1.
  - In KEY*: key_we dropped, key_valid=0 -> IDLE, which retries the rekey.
  - In WAIT_DONE: rsp_ct=0, rsp_err=1, key_valid=0 -> RESP.
- key_ack/done outside their wait states are ignored.
- Reset mid-operation: immediate return to reset values; any in-flight request is lost; the engine is re-keyed.

Optional Feature:
- SIMON_SCHED_STATS_EN defined: adds outputs enc_count[15:0] (successful encryptions) and rekey_count[7:0] (completed key loads). Both saturating, zero on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, engine acks key_we after 3 cycles -> key_addr 9'h10 then 9'h11, one key_we=0 cycle between words, busy=0 after second clear.
- req0_pt=32'hDEADBEEF, done asserted 20 cycles after cipher_en -> req0_ready pulse, single-cycle cipher_en, plaintext=32'hDEADBEEF, rsp_valid with rsp_id=0 and rsp_ct=captured cipher_out.
- Both requesters held valid for 4 encryptions -> grant order 0,1,0,1; rsp_ready held low 5 cycles -> rsp_valid held and no new grant.
- REKEY_INTERVAL=2, continuous requests -> key sequence (9'h10, 9'h11) reissued after every 2nd response, before the next grant.
- done never asserted, TIMEOUT=15 -> 15 cycles after entering WAIT_DONE: rsp_err=1, rsp_ct=0, err_timeout=1; next request is preceded by a rekey.
- rst=0 during WAIT_DONE -> next cycle all outputs 0 and state KEY0; with SIMON_SCHED_STATS_EN, enc_count=0 and rekey_count=0.
